// File: rtl/scan_reg_pkg.sv
// Shared definitions for the scan-testable register bank: operating-mode
// encodings and elaboration-time helpers (chain sizing, log2, parity).
package scan_reg_pkg;

  localparam logic MODE_FUNC  = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAXW = 64;

  // Flops per chain when TOTAL bits are spread over n chains (rounded up).
  function automatic int chain_len(input int total, input int n);
    return (total + n - 1) / n;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic parity(input logic [PAR_MAXW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/scan_shift_ctr.sv
// Shift counter for the register-bank scan chains. Counts consecutive shift
// cycles and raises a one-cycle shift_done after CHAIN_LEN of them, i.e. when
// a complete chain load/unload has happened. Any gap resets the count.
module scan_shift_ctr
  import scan_reg_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic shift,
  output logic shift_done
);

  localparam int CW = (clog2(CHAIN_LEN) < 1) ? 1 : clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  logic [CW-1:0] count;

  // Count shift cycles; wrap and flag on the last position, clear on any gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      shift_done <= 1'b0;
    end else if (shift) begin
      if (count == LAST) begin
        count      <= '0;
        shift_done <= 1'b1;
      end else begin
        count      <= count + CW'(1);
        shift_done <= 1'b0;
      end
    end else begin
      count      <= '0;
      shift_done <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_reg_bank.sv
// Scan-testable register bank: DEPTH words of WIDTH bits with a functional
// write port and a registered read port. All storage lives directly in
// N_CHAINS balanced scan chains; flattened bit k sits in chain k%N_CHAINS at
// position k/N_CHAINS, and unused tail positions are padding flops.
// Optional build macro: SCAN_REG_PARITY_EN adds a stored even-parity bit per
// word (scanned like data) and drives rd_err with the registered mismatch.
module scan_reg_bank
  import scan_reg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int N_CHAINS = 2,
  parameter int AW       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                test_mode,
  input  logic                scan_en,
  input  logic [N_CHAINS-1:0] scan_in,
  output logic [N_CHAINS-1:0] scan_out,
  output logic                shift_done,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_err
);

`ifdef SCAN_REG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int WB        = WIDTH + PAR_BITS;
  localparam int TOTAL     = DEPTH * WB;
  localparam int CHAIN_LEN = chain_len(TOTAL, N_CHAINS);

  logic [N_CHAINS-1:0][CHAIN_LEN-1:0] chain_q;
  logic [TOTAL-1:0]                   flat;
  logic [WB-1:0]                      wr_word;
  logic [WB-1:0]                      rd_word;
  logic                               mode;
  logic                               wr_hit;

  assign mode   = (test_mode && scan_en) ? MODE_SHIFT : MODE_FUNC;
  assign wr_hit = wr_en && (int'(wr_addr) < DEPTH);

`ifdef SCAN_REG_PARITY_EN
  assign wr_word = {parity(PAR_MAXW'(wr_data)), wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Word-ordered view of the storage, unscrambled from the chain layout.
  for (genvar k = 0; k < TOTAL; k++) begin : g_flat
    assign flat[k] = chain_q[k % N_CHAINS][k / N_CHAINS];
  end

  // Last flop of each chain drives the chain output with no logic after it.
  for (genvar c = 0; c < N_CHAINS; c++) begin : g_scan_out
    assign scan_out[c] = chain_q[c][CHAIN_LEN-1];
  end

  // Storage: reset clears everything, shift moves every chain one place
  // (padding included), otherwise a valid write updates the addressed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else if (mode == MODE_SHIFT) begin
      for (int c = 0; c < N_CHAINS; c++) begin
        chain_q[c][0] <= scan_in[c];
        for (int p = 1; p < CHAIN_LEN; p++) begin
          chain_q[c][p] <= chain_q[c][p-1];
        end
      end
    end else if (wr_hit) begin
      for (int k = 0; k < TOTAL; k++) begin
        if (k / WB == int'(wr_addr)) begin
          chain_q[k % N_CHAINS][k / N_CHAINS] <= wr_word[k % WB];
        end
      end
    end
  end

  // Read mux over the pre-write storage; out-of-range addresses read zero.
  always_comb begin
    rd_word = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (int'(rd_addr) == w) rd_word = flat[w*WB +: WB];
    end
  end

  // Registered read data; frozen while the chains are shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (mode == MODE_FUNC) begin
      rd_data <= rd_word[WIDTH-1:0];
    end
  end

`ifdef SCAN_REG_PARITY_EN
  logic rd_err_q;

  // Parity check of the word being read, aligned with rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_err_q <= 1'b0;
    end else if (mode == MODE_FUNC) begin
      rd_err_q <= ^rd_word;
    end
  end

  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

  scan_shift_ctr #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shift_ctr (
    .clk       (clk),
    .reset     (reset),
    .shift     (mode == MODE_SHIFT),
    .shift_done(shift_done)
  );

endmodule

// File: tb/tb_scan_reg_bank.sv
// Self-checking bench for scan_reg_bank (default parameters). Reference model
// holds the bank as one flat bit array in scan order; per-cycle expectations
// are queued by the driver and consumed by an independent monitor.
module tb_scan_reg_bank;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int N_CHAINS = 2;
  localparam int AW       = 2;
`ifdef SCAN_REG_PARITY_EN
  localparam int WB = WIDTH + 1;
`else
  localparam int WB = WIDTH;
`endif
  localparam int TOTAL = DEPTH * WB;
  localparam int CL    = (TOTAL + N_CHAINS - 1) / N_CHAINS;
  localparam int SPACE = CL * N_CHAINS;

  logic                clk;
  logic                reset;
  logic                test_mode;
  logic                scan_en;
  logic [N_CHAINS-1:0] scan_in;
  logic [N_CHAINS-1:0] scan_out;
  logic                shift_done;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [AW-1:0]       rd_addr;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_err;

  scan_reg_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .N_CHAINS(N_CHAINS), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .test_mode(test_mode), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(scan_out), .shift_done(shift_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]    rd_data;
    logic                rd_err;
    logic [N_CHAINS-1:0] scan_out;
    logic                shift_done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: fl[k] is flattened bit k (k >= TOTAL are padding).
  bit               fl[SPACE];
  logic [WIDTH-1:0] m_rd;
  logic             m_err;
  int               m_run;
  logic             m_done;

  function automatic logic [WB-1:0] m_word(input int w);
    logic [WB-1:0] r;
    for (int b = 0; b < WB; b++) r[b] = fl[w*WB + b];
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue expectation.
  task automatic cyc(input logic r, input logic tm, input logic se,
                     input logic [N_CHAINS-1:0] si, input logic we,
                     input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                     input logic [AW-1:0] ra);
    exp_t          e;
    bit            old[SPACE];
    logic [WB-1:0] w;
    @(negedge clk);
    reset = r; test_mode = tm; scan_en = se; scan_in = si;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    if (r) begin
      foreach (fl[k]) fl[k] = 1'b0;
      m_rd = '0; m_err = 1'b0; m_run = 0; m_done = 1'b0;
    end else if (tm && se) begin
      old = fl;
      for (int k = 0; k < SPACE; k++) fl[k] = (k < N_CHAINS) ? si[k] : old[k - N_CHAINS];
      m_run++;
      if (m_run == CL) begin m_run = 0; m_done = 1'b1; end
      else m_done = 1'b0;
    end else begin
      if (int'(ra) < DEPTH) begin
        w = m_word(int'(ra));
        m_rd = w[WIDTH-1:0];
`ifdef SCAN_REG_PARITY_EN
        m_err = ^w;
`else
        m_err = 1'b0;
`endif
      end else begin
        m_rd = '0; m_err = 1'b0;
      end
      if (we && int'(wa) < DEPTH) begin
        for (int b = 0; b < WIDTH; b++) fl[int'(wa)*WB + b] = wd[b];
`ifdef SCAN_REG_PARITY_EN
        fl[int'(wa)*WB + WIDTH] = ^wd;
`endif
      end
      m_run = 0; m_done = 1'b0;
    end
    e.rd_data = m_rd;
    e.rd_err = m_err;
    for (int c = 0; c < N_CHAINS; c++) e.scan_out[c] = fl[(CL-1)*N_CHAINS + c];
    e.shift_done = m_done;
    exp_q.push_back(e);
  endtask

  // Monitor: each clock with a pending expectation, compare the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("rd_data", 32'(rd_data), 32'(e.rd_data));
        compare("rd_err", 32'(rd_err), 32'(e.rd_err));
        compare("scan_out", 32'(scan_out), 32'(e.scan_out));
        compare("shift_done", 32'(shift_done), 32'(e.shift_done));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_CHAINS-1:0] si;
    reset = 1'b1; test_mode = 1'b0; scan_en = 1'b0; scan_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Reset, then basic write/read and read-during-write ordering.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 8'hA5, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 1, 2, 8'h5A, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 2);

    // Full load then full unload of a random pattern.
    for (int i = 0; i < 2*CL; i++) begin
      si = N_CHAINS'($urandom);
      cyc(0, 1, 1, si, 0, 0, 0, 2);
    end
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 0, 0, 0, 0, AW'(a));

    // Unload a known word with zeros shifted in.
    cyc(0, 0, 0, 0, 1, 0, 8'h3C, 0);
    for (int i = 0; i < CL; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 0, 0, 0, 0, AW'(a));

    // scan_en without test_mode is functional; partial load never flags.
    cyc(0, 0, 1, 2'b11, 1, 1, 8'hFF, 1);
    cyc(0, 0, 1, 2'b11, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, N_CHAINS'($urandom), 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CL - 1; i++) cyc(0, 1, 1, N_CHAINS'($urandom), 0, 0, 0, 1);
    cyc(1, 1, 1, 2'b11, 1, 1, 8'h77, 1);
    for (int i = 0; i < CL; i++) cyc(0, 1, 1, N_CHAINS'($urandom), 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

`ifdef SCAN_REG_PARITY_EN
    // Recirculate the chains once, inverting word 0's parity bit on the way.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 8'h01, 0);
    for (int t = 1; t <= CL; t++) begin
      for (int c = 0; c < N_CHAINS; c++) si[c] = fl[(CL-1)*N_CHAINS + c];
      if (t == CL - WIDTH / N_CHAINS) si[WIDTH % N_CHAINS] = ~si[WIDTH % N_CHAINS];
      cyc(0, 1, 1, si, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Random mix, with a full-length shift burst every 100 cycles.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 50) begin
        for (int j = 0; j < CL + int'($urandom_range(0, 3)); j++)
          cyc(0, 1, 1, N_CHAINS'($urandom), 1, AW'($urandom), WIDTH'($urandom), AW'($urandom));
      end else begin
        cyc(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
            N_CHAINS'($urandom), ($urandom % 2) == 0, AW'($urandom),
            WIDTH'($urandom), AW'($urandom));
      end
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
